// File: rtl/sd_seq_pkg.sv
// sd_seq_pkg: shared constants, state encoding and command-word packing for the SD command sequencer
package sd_seq_pkg;
  localparam logic [1:0] REG_ARG    = 2'd0;
  localparam logic [1:0] REG_CMD    = 2'd1;
  localparam logic [1:0] REG_STATUS = 2'd2;
  localparam logic [1:0] REG_RESP   = 2'd3;
  localparam int ST_BUSY = 0;
  localparam int ST_DONE = 1;
  localparam int ST_ERR  = 2;
  localparam int CMD_IDX_LSB  = 0;
  localparam int CMD_TYPE_LSB = 8;
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_CTRL  = 2'b01;
  localparam logic [1:0] ERR_TMO   = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ARG, S_WR_CMD, S_POLL_A, S_POLL_S, S_GAP, S_RESP_A, S_RESP_S, S_FIN
  } state_t;
  function automatic logic [31:0] cmd_word(input logic [5:0] idx, input logic [1:0] typ);
    logic [31:0] w;
    w = '0;
    w[CMD_IDX_LSB+:6]  = idx;
    w[CMD_TYPE_LSB+:2] = typ;
    return w;
  endfunction
endpackage

// File: rtl/sd_seq_timer.sv
// sd_seq_timer: clearable timeout counter, tc flags the cycle whose increment reaches TIMEOUT_CYCLES
// ports: clk, reset (sync, high), clr (zero count), en (count this cycle), tc (terminal count)
module sd_seq_timer #(
  parameter int TW             = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tc
);
  logic [TW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = clr ? '0 : en ? cnt_q + 1'b1 : cnt_q;
    tc    = en && (({1'b0, cnt_q} + (TW+1)'(1)) == (TW+1)'(TIMEOUT_CYCLES));
  end
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
endmodule

// File: rtl/sd_cmd_sequencer.sv
// sd_cmd_sequencer: issues one SD command via the controller's 4-register port and returns err/rsp
// ports: req_* command request handshake; abort; busy/done/err/rsp result;
//        sd_addr/sd_we/sd_out/sd_in controller register port (read data one cycle after address)
module sd_cmd_sequencer
  import sd_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int POLL_GAP       = 4,
  parameter int TW             = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [5:0]  req_index,
  input  logic [1:0]  req_rsp_type,
  input  logic [31:0] req_arg,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err,
  output logic [31:0] rsp,
  output logic [1:0]  sd_addr,
  output logic        sd_we,
  output logic [31:0] sd_out,
  input  logic [31:0] sd_in
);
  localparam int GW = POLL_GAP > 1 ? $clog2(POLL_GAP) : 1;
  state_t state_q, state_d;
  logic [5:0] idx_q, idx_d;
  logic [1:0] typ_q, typ_d, err_q, err_d;
  logic [31:0] arg_q, arg_d, rsp_q, rsp_d;
  logic [GW-1:0] gap_q, gap_d;
  logic t_clr, t_en, tc, st_fin;
  sd_seq_timer #(.TW(TW), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timer (
    .clk(clk), .reset(reset), .clr(t_clr), .en(t_en), .tc(tc)
  );
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    typ_d   = typ_q;
    arg_d   = arg_q;
    err_d   = err_q;
    rsp_d   = rsp_q;
    gap_d   = gap_q;
    t_clr   = 1'b0;
    t_en    = state_q inside {S_POLL_A, S_POLL_S, S_GAP, S_RESP_A, S_RESP_S};
    sd_addr = REG_ARG;
    sd_we   = 1'b0;
    sd_out  = '0;
    // short-busy responses complete only once the card has released busy
    st_fin  = sd_in[ST_DONE] && (sd_in[ST_ERR] || !(typ_q == 2'd3 && sd_in[ST_BUSY]));
    case (state_q)
      S_IDLE: if (req_valid) begin
        idx_d   = req_index;
        typ_d   = req_rsp_type;
        arg_d   = req_arg;
        err_d   = ERR_OK;
        rsp_d   = '0;
        state_d = S_WR_ARG;
      end
      S_WR_ARG: begin
        sd_we   = 1'b1;
        sd_out  = arg_q;
        state_d = S_WR_CMD;
      end
      S_WR_CMD: begin
        sd_addr = REG_CMD;
        sd_we   = 1'b1;
        sd_out  = cmd_word(idx_q, typ_q);
        t_clr   = 1'b1;
        state_d = S_POLL_A;
      end
      S_POLL_A: begin
        sd_addr = REG_STATUS;
        state_d = S_POLL_S;
      end
      S_POLL_S: begin
        gap_d   = '0;
        err_d   = st_fin && sd_in[ST_ERR] ? ERR_CTRL : ERR_OK;
        state_d = !st_fin ? S_GAP : (sd_in[ST_ERR] || typ_q == 2'd0) ? S_FIN : S_RESP_A;
      end
      S_GAP: begin
        gap_d   = gap_q + 1'b1;
        state_d = gap_q == GW'(POLL_GAP - 1) ? S_POLL_A : S_GAP;
      end
      S_RESP_A: begin
        sd_addr = REG_RESP;
        state_d = S_RESP_S;
      end
      S_RESP_S: begin
        rsp_d   = sd_in;
        err_d   = ERR_OK;
        state_d = S_FIN;
      end
      default: state_d = S_IDLE;
    endcase
    // abort outranks timeout, which outranks whatever the status/response sample decided
    if (abort && state_q != S_IDLE && state_q != S_FIN) begin
      state_d = S_FIN;
      err_d   = ERR_ABORT;
      rsp_d   = rsp_q;
    end else if (tc) begin
      state_d = S_FIN;
      err_d   = ERR_TMO;
      rsp_d   = rsp_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      typ_q   <= '0;
      arg_q   <= '0;
      err_q   <= ERR_OK;
      rsp_q   <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      typ_q   <= typ_d;
      arg_q   <= arg_d;
      err_q   <= err_d;
      rsp_q   <= rsp_d;
      gap_q   <= gap_d;
    end
  end
  assign req_ready = state_q == S_IDLE;
  assign busy      = state_q != S_IDLE;
  assign done      = state_q == S_FIN;
  assign err       = err_q;
  assign rsp       = rsp_q;
endmodule

// File: tb/tb_sd_cmd_sequencer.sv
// tb_sd_cmd_sequencer: directed bench with a cycle-level transaction model and per-cycle compare
module tb_sd_cmd_sequencer;
  localparam int T = 20;
  localparam int G = 2;
  localparam int P = G + 2;
  logic clk = 1'b0, reset = 1'b1;
  logic req_valid = 1'b0, abort = 1'b0;
  logic [5:0] req_index = '0;
  logic [1:0] req_rsp_type = '0;
  logic [31:0] req_arg = '0;
  logic req_ready, busy, done, sd_we;
  logic [1:0] err, sd_addr;
  logic [31:0] rsp, sd_out;
  logic [31:0] sd_in = '0;
  sd_cmd_sequencer #(.TIMEOUT_CYCLES(T), .POLL_GAP(G), .TW(16)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_index(req_index), .req_rsp_type(req_rsp_type), .req_arg(req_arg), .abort(abort),
    .busy(busy), .done(done), .err(err), .rsp(rsp),
    .sd_addr(sd_addr), .sd_we(sd_we), .sd_out(sd_out), .sd_in(sd_in)
  );
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask
  // controller model: scripted status per poll (last entry repeats), fixed response word
  logic [31:0] st_seq [8];
  int st_len = 1;
  logic [31:0] resp_val = '0;
  int poll_i = 0;
  always @(posedge clk) begin
    if (req_valid && req_ready) poll_i <= 0;
    else if (sd_addr == 2'd2 && !sd_we) begin
      sd_in  <= st_seq[poll_i < st_len ? poll_i : st_len - 1];
      poll_i <= poll_i + 1;
    end else if (sd_addr == 2'd3 && !sd_we) sd_in <= resp_val;
  end
  // transaction expectations, cycle offsets relative to the accept cycle
  int m_fin, m_rr;
  logic [1:0] m_err;
  logic [31:0] m_rsp, m_arg, m_word;
  logic m_cmd;
  task automatic model(input logic [5:0] idx, input logic [1:0] typ, input logic [31:0] arg,
                       input logic [31:0] resp, input int k);
    int f, rr, pa;
    logic [1:0] e;
    logic [31:0] r, s;
    f = 1000; rr = -1; e = 2'd0; r = '0;
    for (int n = 1; n <= 40; n++) begin
      pa = 3 + (n - 1) * P;
      s = st_seq[(n - 1) < st_len ? n - 1 : st_len - 1];
      if (s[1] && (s[2] || !(typ == 2'd3 && s[0]))) begin
        f = (s[2] || typ == 2'd0) ? pa + 2 : pa + 4;
        e = s[2] ? 2'd1 : 2'd0;
        if (!s[2] && typ != 2'd0) begin r = resp; rr = pa + 2; end
        break;
      end
    end
    if (T + 3 <= f) begin f = T + 3; e = 2'd2; end
    if (k >= 1 && k + 1 <= f) begin f = k + 1; e = 2'd3; end
    if (e != 2'd0) r = '0;
    if (rr >= f) rr = -1;
    m_fin = f; m_rr = rr; m_err = e; m_rsp = r;
    m_arg = arg; m_word = 32'(typ) * 256 + 32'(idx); m_cmd = f > 2;
    resp_val = resp;
  endtask
  logic in_txn = 1'b0, fin_seen = 1'b0;
  int acc = 0, fin_rel = 0, rel;
  logic [1:0] hold_err = '0;
  logic [31:0] hold_rsp = '0;
  always @(negedge clk) begin
    if (reset) begin
      in_txn = 1'b0; hold_err = '0; hold_rsp = '0;
    end else if (in_txn) begin
      rel = cyc - acc;
      chk("busy", busy, 1);
      chk("ready_busy", req_ready, 0);
      chk("done", done, rel == m_fin);
      chk("we", sd_we, rel == 1 || (rel == 2 && m_cmd));
      if (sd_we) begin
        chk("wr_addr", sd_addr, rel == 1 ? 0 : 1);
        chk("wr_data", sd_out, rel == 1 ? m_arg : m_word);
      end
      chk("poll", sd_addr == 2 && !sd_we, rel >= 3 && rel < m_fin && (rel - 3) % P == 0);
      chk("resp_rd", sd_addr == 3 && !sd_we, rel == m_rr);
      if (done || rel >= m_fin) begin
        chk("err", err, m_err);
        chk("rsp", rsp, m_rsp);
        hold_err = m_err; hold_rsp = m_rsp;
        fin_rel = rel; fin_seen = 1'b1; in_txn = 1'b0;
      end
    end else begin
      chk("idle_busy", busy, 0);
      chk("idle_ready", req_ready, 1);
      chk("idle_done", done, 0);
      chk("idle_we", sd_we, 0);
      chk("hold_err", err, hold_err);
      chk("hold_rsp", rsp, hold_rsp);
      if (req_valid && req_ready) begin in_txn = 1'b1; acc = cyc; end
    end
  end
  task automatic set_st(input logic [31:0] a, b, c, d, input int n);
    st_seq[0] = a; st_seq[1] = b; st_seq[2] = c; st_seq[3] = d; st_len = n;
  endtask
  task automatic start(input logic [5:0] idx, input logic [1:0] typ, input logic [31:0] arg);
    fin_seen = 1'b0;
    req_valid = 1'b1; req_index = idx; req_rsp_type = typ; req_arg = arg;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask
  task automatic run(input logic [5:0] idx, input logic [1:0] typ, input logic [31:0] arg,
                     input logic [31:0] resp, input int k);
    model(idx, typ, arg, resp, k);
    start(idx, typ, arg);
    for (int r = 1; r < 300 && !fin_seen; r++) begin
      abort = (r == k);
      @(posedge clk); #1;
    end
    abort = 1'b0;
    chk("done_seen", fin_seen, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got running expected finished");
    $fatal(1);
  end
  initial begin
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_we", sd_we, 0);
    chk("rst_addr", sd_addr, 0);
    chk("rst_out", sd_out, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_rsp", rsp, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", req_ready, 1);
    @(posedge clk); #1;
    set_st(32'h2, 0, 0, 0, 1);
    run(6'd0, 2'd0, 32'h0, 32'h0, -1);
    chk("cmd0_latency", fin_rel + 1, 6);
    set_st(32'h1, 32'h1, 32'h1, 32'h2, 4);
    run(6'd8, 2'd1, 32'h1AA, 32'h1AA, -1);
    chk("cmd8_word", m_word, 32'h108);
    chk("cmd8_rsp", rsp, 32'h1AA);
    chk("cmd8_fin", fin_rel, 19);
    set_st(32'h1, 0, 0, 0, 1);
    run(6'd17, 2'd1, 32'h200, 32'h55, -1);
    chk("tmo_fin", fin_rel, 23);
    chk("tmo_err", err, 2);
    chk("tmo_rsp", rsp, 0);
    set_st(32'h6, 0, 0, 0, 1);
    run(6'd17, 2'd1, 32'h1000, 32'h77, -1);
    chk("cerr_err", err, 1);
    chk("cerr_rsp", rsp, 0);
    set_st(32'h2, 0, 0, 0, 1);
    run(6'd8, 2'd1, 32'h1AA, 32'h1AA, 1);
    chk("abort_arg_fin", fin_rel, 2);
    chk("abort_arg_err", err, 3);
    set_st(32'h1, 0, 0, 0, 1);
    run(6'd9, 2'd2, 32'h3, 32'h4, T + 2);
    chk("abort_tmo_fin", fin_rel, 23);
    chk("abort_tmo_err", err, 3);
    set_st(32'h1, 0, 0, 0, 1);
    run(6'd9, 2'd1, 32'h3, 32'h4, 6);
    chk("abort_gap_fin", fin_rel, 7);
    set_st(32'h3, 32'h3, 32'h2, 0, 3);
    run(6'd7, 2'd3, 32'hABCD, 32'h900, -1);
    chk("busy_fin", fin_rel, 15);
    chk("busy_rsp", rsp, 32'h900);
    set_st(32'h1, 32'h2, 0, 0, 2);
    run(6'd2, 2'd2, 32'h0, 32'hDEADBEEF, -1);
    chk("long_rsp", rsp, 32'hDEADBEEF);
    set_st(32'h1, 0, 0, 0, 1);
    model(6'd17, 2'd1, 32'h42, 32'h0, -1);
    start(6'd17, 2'd1, 32'h42);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    chk("gap_rst_ready", req_ready, 1);
    chk("gap_rst_busy", busy, 0);
    chk("gap_rst_done", done, 0);
    repeat (30) @(posedge clk);
    #1;
    set_st(32'h2, 0, 0, 0, 1);
    run(6'd55, 2'd0, 32'hCAFE, 32'h0, -1);
    chk("post_rst_fin", fin_rel, 5);
    chk("post_rst_err", err, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
